// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB bus arbiter with lock, error release and timeout
// Grants one master at a time; outputs are registered and cleared on every release.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [NUM_MASTERS-1:0]       hreq,
    input  logic [NUM_MASTERS-1:0]       hlock,
    input  logic [NUM_MASTERS*SEL_W-1:0] sel_in,
    input  logic                         hready_out,
    input  logic                         hresp,
    output logic [NUM_MASTERS-1:0]       hgrant,
    output logic [MIDX_W-1:0]            hmaster,
    output logic [SEL_W-1:0]             sel,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int                 CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [MIDX_W-1:0]  LAST_RST = MIDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   hgrant_q, hgrant_d;
    logic [MIDX_W-1:0]        hmaster_q, hmaster_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [MIDX_W-1:0]        last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tout_q, tout_d;

    logic [SEL_W-1:0]         sel_arr [NUM_MASTERS];
    logic [MIDX_W-1:0]        winner;
    logic                     found;
    logic                     tr_done;
    logic                     err;

    assign tr_done = hready_out & ~hresp;
    assign err     = hready_out &  hresp;

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            sel_arr[i] = sel_in[i*SEL_W +: SEL_W];
        end
    end

    // Scan starts just above the last winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (!found && hreq[MIDX_W'((int'(last_q) + k) % NUM_MASTERS)]) begin
                found  = 1'b1;
                winner = MIDX_W'((int'(last_q) + k) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        hgrant_d  = hgrant_q;
        hmaster_d = hmaster_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                hgrant_d  = '0;
                hmaster_d = '0;
                sel_d     = '0;
                cnt_d     = '0;
                if (found) begin
                    state_d   = GRANT;
                    hgrant_d  = NUM_MASTERS'(1) << winner;
                    hmaster_d = winner;
                    sel_d     = sel_arr[winner];
                    last_d    = winner;
                end
            end
            GRANT: begin
                if (tr_done && hlock[hmaster_q] && hreq[hmaster_q]) begin
                    cnt_d = '0;
                end else if (tr_done || err || (cnt_q == CNT_MAX)) begin
                    // Completion and error win over a timeout landing in the same cycle.
                    tout_d    = !(tr_done || err);
                    state_d   = IDLE;
                    hgrant_d  = '0;
                    hmaster_d = '0;
                    sel_d     = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                hgrant_d  = '0;
                hmaster_d = '0;
                sel_d     = '0;
                cnt_d     = '0;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= IDLE;
            hgrant_q  <= '0;
            hmaster_q <= '0;
            sel_q     <= '0;
            last_q    <= LAST_RST;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hgrant_q  <= hgrant_d;
            hmaster_q <= hmaster_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
        end
    end

    assign hgrant      = hgrant_q;
    assign hmaster     = hmaster_q;
    assign sel         = sel_q;
    assign busy        = (state_q == GRANT);
    assign timeout_err = tout_q;

endmodule
